// File: rtl/bram_ssp_ctrl_if.sv
// Client-side request/response bundle for bram_ssp_ctrl.
// master = client, slave = controller.
interface bram_ssp_ctrl_if #(
  parameter int DEPTH_LOG = 8,
  parameter int WIDTH     = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [DEPTH_LOG-1:0] req_addr;
  logic [WIDTH-1:0]     req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WIDTH-1:0]     rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/bram_ssp_ctrl.sv
// Single-port BRAM front end: credit-gated requests, 3-entry in-order
// response FIFO. Optional zero-fill sweep after reset: BRAM_SSP_INIT_EN.
module bram_ssp_ctrl #(
  parameter int DEPTH     = 256,
  parameter int DEPTH_LOG = 8,
  parameter int WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  bram_ssp_ctrl_if.slave       bus,
  output logic                 busy,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [DEPTH_LOG-1:0] mem_addr,
  output logic [WIDTH-1:0]     mem_din,
  input  logic [WIDTH-1:0]     mem_dout
);

  if (DEPTH > (2 ** DEPTH_LOG)) begin : g_chk
    $error("DEPTH does not fit in DEPTH_LOG address bits");
  end

  typedef enum logic {INIT, RUN} state_t;

`ifdef BRAM_SSP_INIT_EN
  localparam state_t RST_STATE = INIT;
  localparam logic [DEPTH_LOG-1:0] LAST = DEPTH_LOG'(DEPTH - 1);
  logic [DEPTH_LOG-1:0] sweep;
`else
  localparam state_t RST_STATE = RUN;
`endif

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       occ;
  logic             pend;
  logic [1:0]       wptr;
  logic [1:0]       rptr;
  logic [WIDTH-1:0] fifo [0:2];
  logic [2:0]       occ_pend;
  logic             rdy;
  logic             acc;
  logic             pop;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // credit: in-flight plus buffered must leave room for this request
  assign occ_pend      = {1'b0, occ} + {2'b0, pend};
  assign rdy           = (state == RUN) && !rst && (occ_pend < 3'd3);
  assign acc           = bus.req_valid && rdy;
  assign pop           = (occ != 2'd0) && bus.rsp_ready;
  assign bus.req_ready = rdy;
  assign bus.rsp_valid = (occ != 2'd0);
  assign bus.rsp_rdata = fifo[rptr];

`ifdef BRAM_SSP_INIT_EN
  assign busy = (state == INIT);
`else
  assign busy = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RST_STATE;
    else     state <= state_nxt;
  end

  // next state and RAM port drive
  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_din   = '0;
    unique case (1'b1)
      (state == INIT): begin
`ifdef BRAM_SSP_INIT_EN
        if (!rst) begin
          mem_en   = 1'b1;
          mem_we   = 1'b1;
          mem_addr = sweep;
          if (sweep == LAST) state_nxt = RUN;
        end
`else
        state_nxt = RUN;
`endif
      end
      (state == RUN): begin
        if (!rst) begin
          mem_en   = acc;
          mem_we   = bus.req_we;
          mem_addr = bus.req_addr;
          mem_din  = bus.req_wdata;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

`ifdef BRAM_SSP_INIT_EN
  // zero-fill sweep address, restarts on every reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 sweep <= '0;
    else if (state == INIT)  sweep <= sweep + 1'b1;
  end
`endif

  // in-flight flag and response FIFO; dout lands one cycle after issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
      occ  <= 2'd0;
      wptr <= 2'd0;
      rptr <= 2'd0;
      for (int i = 0; i < 3; i++) fifo[i] <= '0;
    end else begin
      pend <= acc;
      if (pend) begin
        fifo[wptr] <= mem_dout;
        wptr       <= nxt(wptr);
      end
      if (pop) rptr <= nxt(rptr);
      if (pend && !pop)      occ <= occ + 2'd1;
      else if (!pend && pop) occ <= occ - 2'd1;
    end
  end

endmodule

// File: tb/tb_bram_ssp_ctrl.sv
// Bench for bram_ssp_ctrl: behavioural RAM, queue-based response model,
// per-cycle compare plus directed literal checks.
module tb_bram_ssp_ctrl;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int DW    = 32;
`ifdef BRAM_SSP_INIT_EN
  localparam int   INIT_CYC = DEPTH;
  localparam logic BUSY_RST = 1'b1;
`else
  localparam int   INIT_CYC = 0;
  localparam logic BUSY_RST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          busy;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;

  bram_ssp_ctrl_if #(.DEPTH_LOG(AW), .WIDTH(DW)) bus ();

  bram_ssp_ctrl #(.DEPTH(DEPTH), .DEPTH_LOG(AW), .WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_dout (mem_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input int a);
    return 32'hC0DE_0000 | DW'(a);
  endfunction

  // RAM: write-first, 1-cycle read latency, unwritten words = pat(addr)
  logic [DW-1:0] ram [DEPTH];
  bit            ram_w [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]   <= mem_din;
        ram_w[mem_addr] <= 1'b1;
        mem_dout        <= mem_din;
      end else begin
        mem_dout <= ram_w[mem_addr] ? ram[mem_addr] : pat(int'(mem_addr));
      end
    end
  end

  // model state
  typedef struct {
    logic [DW-1:0] d;
    int            rc;
  } ent_t;

  ent_t          q[$];
  logic [DW-1:0] mmem [DEPTH];
  bit            mw [DEPTH];
  logic [DW-1:0] log_q[$];
  logic [DW-1:0] want[$];
  int            cyc = 0;
`ifdef BRAM_SSP_INIT_EN
  int            sweep = 0;
`else
  int            sweep = DEPTH;
`endif
  int            errs = 0;
  int            checks = 0;
  bit            s_valid;
  logic [DW-1:0] s_data;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit exp_valid();
    return !rst && q.size() > 0 && q[0].rc <= cyc;
  endfunction

  function automatic bit exp_ready();
    return !rst && sweep >= DEPTH && q.size() < 3;
  endfunction

  // per-cycle compare, mid-cycle
  always @(negedge clk) begin
    bit e;
    s_valid = bus.rsp_valid;
    s_data  = bus.rsp_rdata;
    if (rst) begin
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 0);
      chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 0);
      chk("rst_req_ready", 64'(bus.req_ready), 0);
      chk("rst_mem_en", 64'(mem_en), 0);
      chk("rst_mem_we", 64'(mem_we), 0);
      chk("rst_mem_addr", 64'(mem_addr), 0);
      chk("rst_mem_din", 64'(mem_din), 0);
      chk("rst_busy", 64'(busy), 64'(BUSY_RST));
    end else begin
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(exp_valid()));
      if (exp_valid()) chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(q[0].d));
      chk("req_ready", 64'(bus.req_ready), 64'(exp_ready()));
      chk("busy", 64'(busy), 64'(sweep < DEPTH));
      if (sweep < DEPTH) begin
        chk("init_en", 64'(mem_en), 1);
        chk("init_we", 64'(mem_we), 1);
        chk("init_addr", 64'(mem_addr), 64'(sweep));
        chk("init_din", 64'(mem_din), 0);
      end else begin
        e = bus.req_valid && exp_ready();
        chk("mem_en", 64'(mem_en), 64'(e));
        if (e) begin
          chk("mem_addr", 64'(mem_addr), 64'(bus.req_addr));
          chk("mem_we", 64'(mem_we), 64'(bus.req_we));
          if (bus.req_we) chk("mem_din", 64'(mem_din), 64'(bus.req_wdata));
        end
      end
    end
  end

  // model update at the clock edge
  always @(posedge clk) begin
    bit            v;
    bit            r;
    logic [DW-1:0] d;
    int            a;
    if (rst) begin
      q.delete();
`ifdef BRAM_SSP_INIT_EN
      sweep = 0;
`endif
    end else if (sweep < DEPTH) begin
      mmem[sweep] = '0;
      mw[sweep]   = 1'b1;
      sweep++;
    end else begin
      v = exp_valid();
      r = exp_ready();
      if (s_valid && bus.rsp_ready) log_q.push_back(s_data);
      if (v && bus.rsp_ready) void'(q.pop_front());
      if (bus.req_valid && r) begin
        a = int'(bus.req_addr);
        if (bus.req_we) begin
          mmem[a] = bus.req_wdata;
          mw[a]   = 1'b1;
          d       = bus.req_wdata;
        end else begin
          d = mw[a] ? mmem[a] : pat(a);
        end
        q.push_back('{d: d, rc: cyc + 2});
      end
    end
    cyc++;
  end

  task automatic idle();
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
  endtask

  task automatic send(input bit we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, output int acyc);
    bit got;
    got  = 1'b0;
    acyc = -1;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      got  = bus.req_ready;
      acyc = cyc;
      @(posedge clk);
      #1;
    end
    chk("send_accepted", 64'(got), 1);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_log(input string nm);
    chk({nm, "_count"}, 64'(log_q.size()), 64'(want.size()));
    for (int i = 0; i < want.size() && i < log_q.size(); i++)
      chk(nm, 64'(log_q[i]), 64'(want[i]));
    log_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int a1;
    int first;
    int last;
    int n;
    int n_acc;
    bit got;
    idle();
    bus.rsp_ready = 1'b1;
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    count_busy(n);
    chk("init_busy_cycles", 64'(n), 64'(INIT_CYC));

    // write then read same address, latency 2
    log_q.delete();
    send(1'b1, 8'h10, 32'hDEAD_BEEF, a0);
    send(1'b0, 8'h10, 32'h0, a1);
    idle();
    first = -1;
    for (int k = 0; k < 10 && first < 0; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) first = cyc;
    end
    chk("t1_latency", 64'(first - a0), 2);
    wait_cyc(6);
    want = '{32'hDEAD_BEEF, 32'hDEAD_BEEF};
    chk_log("t1_data");

    // back-to-back writes then reads
    for (int i = 0; i < 4; i++) begin
      send(1'b1, AW'(i), 32'hA0 + DW'(i), a1);
      if (i == 0) first = a1;
    end
    for (int i = 0; i < 4; i++) send(1'b0, AW'(i), 32'h0, last);
    idle();
    chk("t2_span", 64'(last - first), 7);
    wait_cyc(8);
    want = '{32'hA0, 32'hA1, 32'hA2, 32'hA3,
             32'hA0, 32'hA1, 32'hA2, 32'hA3};
    chk_log("t2_data");

    // backpressure: only 3 outstanding
    bus.rsp_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b0;
      bus.req_addr  = AW'(n_acc);
      @(negedge clk);
      got = bus.req_ready;
      @(posedge clk);
      #1;
      if (got) n_acc++;
    end
    chk("t3_accepted", 64'(n_acc), 3);
    @(negedge clk);
    chk("t3_ready_low", 64'(bus.req_ready), 0);
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    while (n_acc < 6) begin
      send(1'b0, AW'(n_acc), 32'h0, a1);
      n_acc++;
    end
    idle();
    wait_cyc(10);
`ifdef BRAM_SSP_INIT_EN
    want = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h0, 32'h0};
`else
    want = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hC0DE_0004, 32'hC0DE_0005};
`endif
    chk_log("t3_data");

    // reset with occ=2, pend=1
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b0, AW'(i), 32'h0, a1);
    idle();
    rst = 1'b1;
    @(negedge clk);
    chk("t4_rsp_valid", 64'(bus.rsp_valid), 0);
    chk("t4_req_ready", 64'(bus.req_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    log_q.delete();
    count_busy(n);
    chk("t4_busy_cycles", 64'(n), 64'(INIT_CYC));
    bus.rsp_ready = 1'b1;
    wait_cyc(10);
    chk("t4_stale", 64'(log_q.size()), 0);

    // top address
    send(1'b1, 8'hFF, 32'h1234_5678, a1);
    send(1'b0, 8'hFF, 32'h0, a1);
    send(1'b0, 8'h00, 32'h0, a1);
    idle();
    wait_cyc(8);
`ifdef BRAM_SSP_INIT_EN
    want = '{32'h1234_5678, 32'h1234_5678, 32'h0};
`else
    want = '{32'h1234_5678, 32'h1234_5678, 32'hA0};
`endif
    chk_log("t5_data");

`ifdef BRAM_SSP_INIT_EN
    // cleared word after sweep
    send(1'b0, 8'h55, 32'h0, a1);
    idle();
    wait_cyc(6);
    want = '{32'h0};
    chk_log("t6_read55");
    // reset in the middle of a sweep
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    wait_cyc(100);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_restart_addr", 64'(mem_addr), 0);
    chk("t6_restart_busy", 64'(busy), 1);
    count_busy(n);
    chk("t6_busy_cycles", 64'(n + 1), 256);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
